// File: rtl/icache_sa_burst.sv
// Read-only set-associative instruction cache with multi-word lines, burst refill,
// round-robin replacement, whole-cache flush and hit/miss counters.
module icache_sa_burst #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned SETS           = 16,
  parameter int unsigned WAYS           = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  output logic [DATA_W-1:0] cpu_resp_data,
  output logic              cpu_resp_valid,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic              mem_resp_valid,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int unsigned BoffW = $clog2(DATA_W / 8);
  localparam int unsigned WoffW = $clog2(WORDS_PER_LINE);
  localparam int unsigned IdxW  = $clog2(SETS);
  localparam int unsigned TagW  = ADDR_W - IdxW - WoffW - BoffW;
  localparam int unsigned WayW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [ADDR_W-1:0] LineMask = {ADDR_W{1'b1}} << (BoffW + WoffW);
  localparam logic [WoffW-1:0]  LastBeat = WoffW'(WORDS_PER_LINE - 1);
  localparam logic [IdxW-1:0]   LastSet  = IdxW'(SETS - 1);

  typedef enum logic [2:0] {
    StIdle, StLookup, StRefillReq, StRefill, StResp, StFlush
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WayW-1:0]   victim_q, victim_d;
  logic              by_ptr_q, by_ptr_d;
  logic [WoffW-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pend_q, pend_d;
  logic [IdxW-1:0]   fidx_q, fidx_d;
  logic [31:0]       hit_q, hit_d, miss_q, miss_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WayW-1:0]   rr_q    [SETS];
  logic [TagW-1:0]   tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS_PER_LINE];

  logic [IdxW-1:0]  idx;
  logic [WoffW-1:0] woff;
  logic [TagW-1:0]  tag;
  logic             hit;
  logic [WayW-1:0]  hit_way;
  logic             inv_found;
  logic [WayW-1:0]  inv_way;
  logic [WayW-1:0]  victim_sel;
  logic [WayW-1:0]  rr_next;
  logic             inval_victim, line_fill, beat_we, flush_clr;

  assign idx  = addr_q[BoffW + WoffW +: IdxW];
  assign woff = addr_q[BoffW +: WoffW];
  assign tag  = addr_q[ADDR_W-1 -: TagW];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
    // Scan downwards so the lowest-numbered invalid way wins.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WayW'(w);
      end
    end
  end

  assign victim_sel = inv_found ? inv_way : rr_q[idx];
  assign rr_next    = (WAYS > 1) ? rr_q[idx] + 1'b1 : '0;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    victim_d       = victim_q;
    by_ptr_d       = by_ptr_q;
    beat_d         = beat_q;
    rdata_d        = rdata_q;
    pend_d         = pend_q;
    fidx_d         = fidx_q;
    hit_d          = hit_q;
    miss_d         = miss_q;
    inval_victim   = 1'b0;
    line_fill      = 1'b0;
    beat_we        = 1'b0;
    flush_clr      = 1'b0;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    mem_req_valid  = 1'b0;

    if (flush && (state_q != StIdle) && (state_q != StFlush)) pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        cpu_req_ready = 1'b1;
        if (flush) begin
          state_d = StFlush;
          fidx_d  = '0;
          pend_d  = 1'b0;
        end else if (cpu_req_valid) begin
          addr_d  = cpu_req_addr;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          rdata_d = data_q[idx][hit_way][woff];
          hit_d   = hit_q + 32'd1;
          state_d = StResp;
        end else begin
          miss_d       = miss_q + 32'd1;
          victim_d     = victim_sel;
          by_ptr_d     = !inv_found;
          inval_victim = 1'b1;
          beat_d       = '0;
          state_d      = StRefillReq;
        end
      end
      StRefillReq: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = StRefill;
      end
      StRefill: begin
        if (mem_resp_valid) begin
          beat_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == woff) rdata_d = mem_resp_data;
          if (beat_q == LastBeat) begin
            line_fill = 1'b1;
            state_d   = StResp;
          end
        end
      end
      StResp: begin
        cpu_resp_valid = 1'b1;
        if (pend_q || flush) begin
          state_d = StFlush;
          fidx_d  = '0;
          pend_d  = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        flush_clr = 1'b1;
        fidx_d    = fidx_q + 1'b1;
        if (fidx_q == LastSet) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cpu_resp_data = rdata_q;
  assign mem_req_addr  = mem_req_valid ? (addr_q & LineMask) : '0;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      victim_q <= '0;
      by_ptr_q <= 1'b0;
      beat_q   <= '0;
      rdata_q  <= '0;
      pend_q   <= 1'b0;
      fidx_q   <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      victim_q <= victim_d;
      by_ptr_q <= by_ptr_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      pend_q   <= pend_d;
      fidx_q   <= fidx_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (inval_victim) valid_q[idx][victim_sel] <= 1'b0;
      if (line_fill) begin
        valid_q[idx][victim_q] <= 1'b1;
        // The pointer only moves when it actually picked the victim.
        if (by_ptr_q) rr_q[idx] <= rr_next;
      end
      if (flush_clr) begin
        valid_q[fidx_q] <= '0;
        rr_q[fidx_q]    <= '0;
      end
    end
  end

  // Tag and data arrays need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (beat_we) data_q[idx][victim_q][beat_q] <= mem_resp_data;
    if (line_fill) tag_q[idx][victim_q] <= tag;
  end

endmodule

// File: doc/icache_sa_burst.md
Name:
icache_sa_burst

Overview:
- Parametrised, read-only, set-associative instruction cache with multi-word lines and burst refill.
- Sits between the fetch stage and the instruction memory port.
- Generalises the single-word direct-mapped I-cache controller with configurable ways, sets and line size, round-robin replacement, a full-cache flush, and hit/miss performance counters.
- No write path; lines are never dirty, so there is no write-back.

Parameters:
- ADDR_W, 32: address width (byte address).
- DATA_W, 32: instruction word width; power of 2, at least 8.
- WORDS_PER_LINE, 4: words per line; power of 2, at least 2.
- SETS, 16: number of sets; power of 2, at least 2.
- WAYS, 2: associativity; power of 2, at least 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req_addr  in  ADDR_W  fetch byte address; low log2(DATA_W/8) bits ignored.
- cpu_req_valid  in  1  fetch request.
- cpu_req_ready  out  1  cache can accept a request this cycle.
- cpu_resp_data  out  DATA_W  fetched word.
- cpu_resp_valid  out  1  one-cycle pulse, data valid; no backpressure.
- flush  in  1  invalidate entire cache.
- mem_req_addr  out  ADDR_W  line-aligned refill address.
- mem_req_valid  out  1  burst read request.
- mem_req_ready  in  1  memory accepts burst request.
- mem_resp_data  in  DATA_W  refill beat data.
- mem_resp_valid  in  1  one beat per asserted cycle, in ascending word order.
- hit_count  out  32  lookups that hit; wraps modulo 2^32.
- miss_count  out  32  lookups that missed; wraps modulo 2^32.

Behaviour:
- Address split (LSB first): byte offset log2(DATA_W/8), then word offset log2(WORDS_PER_LINE), then index log2(SETS), then tag (remaining bits).
- Per line storage: valid bit, tag, data.
- Per set: round-robin victim pointer, log2(WAYS) bits; none when WAYS=1.

States: IDLE, LOOKUP, REFILL_REQ, REFILL, RESP, FLUSH.

IDLE:
- cpu_req_ready=1.
- flush has priority over cpu_req_valid: if flush=1, go to FLUSH and do not accept the request.
- Else if cpu_req_valid=1, register the address and go to LOOKUP.

LOOKUP:
- Compare tag against all ways of the indexed set.
- Hit: latch the word, increment hit_count, go to RESP.
- Miss: increment miss_count, go to REFILL_REQ.
- Victim is the lowest-numbered invalid way; if all ways are valid, the victim is the set's round-robin pointer.

REFILL_REQ:
- mem_req_valid=1, mem_req_addr = registered address with word and byte offsets zeroed.
- Both held stable until the cycle mem_req_ready=1, then go to REFILL.
- Clear the victim line's valid bit on entry.

REFILL:
- Beat counter starts at 0. Each mem_resp_valid writes mem_resp_data to victim word [counter], then counter+1.
- The requested word is captured when its beat arrives.
- After beat WORDS_PER_LINE-1:
  - write the tag and set valid;
  - advance the round-robin pointer, only if the victim was chosen by the pointer;
  - go to RESP.
- Gaps between beats are allowed.

RESP:
- cpu_resp_valid=1 for exactly one cycle with the latched word.
- Go to FLUSH if a flush is pending, else IDLE.

FLUSH:
- cpu_req_ready=0.
- Clear valid bits of one set per cycle, set 0 up to set SETS-1 (SETS cycles), then go to IDLE.
- Round-robin pointers are reset to 0.

Flush while busy:
- flush=1 in LOOKUP, REFILL_REQ, REFILL or RESP sets flush_pending.
- The in-flight request completes and is answered first; the flush then runs.
- flush_pending clears on entry to FLUSH.

Latency:
- Request accepted in cycle A.
- Hit: cpu_resp_valid in cycle A+2; cpu_req_ready high again in A+3.
- Miss: cpu_resp_valid is one cycle after the final refill beat.

Out-of-state inputs:
- mem_resp_valid outside REFILL is ignored.
- cpu_req_valid outside IDLE is ignored; the requester holds the request until it sees ready.

Reset (rst=1, any state, including mid-refill):
- Next cycle: state IDLE; all valid bits, pointers, flush_pending and counters are 0.
- Outputs: cpu_req_ready=1 (IDLE), cpu_resp_valid=0, cpu_resp_data=0, mem_req_valid=0, mem_req_addr=0.
- Late beats of the abandoned burst are dropped.

Test Plan:
- Default params. Reset, then fetch 0x0000_0104, memory returns beats 0xA0..0xA3 for line 0x100 -> mem_req_addr=0x0000_0100, cpu_resp_data=0xA1, miss_count=1.
- Then fetch 0x0000_0108 -> hit; cpu_resp_valid exactly 2 cycles after acceptance with data 0xA2; hit_count=1; no mem_req_valid.
- Fetch 0x104, 0x204, 0x304, then 0x104 (same set 0, WAYS=2) -> four misses. 0x304 evicts 0x104's way 0; the final 0x104 refills into way 1, evicting 0x204; miss_count=4.
- Hold mem_req_ready=0 for 5 cycles and insert 2-cycle gaps between beats -> mem_req_addr stable throughout; correct word returned; exactly one cpu_resp_valid pulse.
- Assert flush during a refill -> the refill completes and responds. FLUSH then lasts 16 cycles with cpu_req_ready=0. A re-fetch of 0x108 misses.
- Assert rst after the second refill beat, then send stray mem_resp_valid beats -> outputs at reset values; counters 0; a fetch of 0x104 misses and refills cleanly.
